// File: rtl/mandelbrot_frame_ctrl.sv
// mandelbrot_frame_ctrl
//   Drives the mandelbrot engine one pixel at a time for one frame, or for
//   back-to-back frames when continuous is set. Frame configuration is held in
//   shadow registers that feed the engine config ports. Each pixel result goes
//   into a small FIFO. The FIFO is presented as a valid/ready pixel stream that
//   carries end-of-line and end-of-frame markers.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   frame_req           pulse: start a frame (dropped while busy)
//   continuous          restart automatically after end of frame
//   cfg_*               frame config, sampled in LOAD only
//   eng_run             one-cycle run pulse per pixel
//   eng_running         engine busy computing a pixel
//   eng_finished        engine end-of-frame flag
//   eng_ctr_out         engine pixel result
//   eng_*               shadow config to the engine
//   pix_valid/ready     pixel stream handshake
//   pix_data/eol/eof    pixel value and line/frame markers
//   busy                frame in progress
//   frame_done          one-cycle pulse after the eof pixel is pushed
//   sync_err            sticky engine/controller position mismatch
module mandelbrot_frame_ctrl #(
    parameter int BITWIDTH   = 10,
    parameter int CTRWIDTH   = 7,
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_req,
    input  logic                continuous,
    input  logic [CTRWIDTH-1:0] cfg_max_ctr,
    input  logic [2:0]          cfg_ctr_sel,
    input  logic [6:0]          cfg_scaling,
    input  logic [BITWIDTH-1:0] cfg_cr_off,
    input  logic [BITWIDTH-1:0] cfg_ci_off,
    output logic                eng_run,
    input  logic                eng_running,
    input  logic                eng_finished,
    input  logic [3:0]          eng_ctr_out,
    output logic [CTRWIDTH-1:0] eng_max_ctr,
    output logic [2:0]          eng_ctr_sel,
    output logic [6:0]          eng_scaling,
    output logic [BITWIDTH-1:0] eng_cr_off,
    output logic [BITWIDTH-1:0] eng_ci_off,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [3:0]          pix_data,
    output logic                pix_eol,
    output logic                pix_eof,
    output logic                busy,
    output logic                frame_done,
    output logic                sync_err
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic                running_q;
    logic                eng_run_q, eng_run_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                sync_err_q, sync_err_d;
    logic [CTRWIDTH-1:0] max_ctr_q, max_ctr_d;
    logic [2:0]          ctr_sel_q, ctr_sel_d;
    logic [6:0]          scaling_q, scaling_d;
    logic [BITWIDTH-1:0] cr_off_q, cr_off_d;
    logic [BITWIDTH-1:0] ci_off_q, ci_off_d;
    logic [5:0]          mem_q [FIFO_DEPTH];
    logic [5:0]          mem_d [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;

    logic push, pop, eol, eof, done;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        frame_done_d = 1'b0;
        sync_err_d   = sync_err_q;
        max_ctr_d    = max_ctr_q;
        ctr_sel_d    = ctr_sel_q;
        scaling_d    = scaling_q;
        cr_off_d     = cr_off_q;
        ci_off_d     = ci_off_q;
        push         = 1'b0;
        eol          = (x_q == XW'(WIDTH - 1));
        eof          = eol && (y_q == YW'(HEIGHT - 1));
        done         = running_q && !eng_running;
        pop          = (count_q != '0) && pix_ready;

        case (state_q)
            S_IDLE: begin
                if (frame_req) state_d = S_LOAD;
            end
            S_LOAD: begin
                max_ctr_d = cfg_max_ctr;
                ctr_sel_d = cfg_ctr_sel;
                scaling_d = cfg_scaling;
                cr_off_d  = cfg_cr_off;
                ci_off_d  = cfg_ci_off;
                x_d       = '0;
                y_d       = '0;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                // eng_run_q is high exactly while ISSUE has FIFO room
                if (eng_run_q) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done) begin
                    push = 1'b1;
                    if (eof && !eng_finished) sync_err_d = 1'b1;
                    if (!eof && eng_finished) sync_err_d = 1'b1;
                    if (eol) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    if (eof) begin
                        y_d          = '0;
                        frame_done_d = 1'b1;
                        state_d      = continuous ? S_LOAD : S_IDLE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {eof, eol, eng_ctr_out};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Run and busy are registered from the next-state values so that they
    // line up with the ISSUE state / non-IDLE states they describe.
    always_comb begin
        eng_run_d = (state_d == S_ISSUE) && (count_d < CW'(FIFO_DEPTH));
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            running_q    <= 1'b0;
            eng_run_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            max_ctr_q    <= '0;
            ctr_sel_q    <= '0;
            scaling_q    <= '0;
            cr_off_q     <= '0;
            ci_off_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            running_q    <= eng_running;
            eng_run_q    <= eng_run_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            max_ctr_q    <= max_ctr_d;
            ctr_sel_q    <= ctr_sel_d;
            scaling_q    <= scaling_d;
            cr_off_q     <= cr_off_d;
            ci_off_q     <= ci_off_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_q        <= mem_d;
        end
    end

    // Issue requires free space, so a push into a full FIFO means a broken engine handshake.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count_q == CW'(FIFO_DEPTH))));

    assign eng_run     = eng_run_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign sync_err    = sync_err_q;
    assign eng_max_ctr = max_ctr_q;
    assign eng_ctr_sel = ctr_sel_q;
    assign eng_scaling = scaling_q;
    assign eng_cr_off  = cr_off_q;
    assign eng_ci_off  = ci_off_q;
    assign pix_valid   = (count_q != '0);
    assign pix_data    = mem_q[rd_ptr_q][3:0];
    assign pix_eol     = mem_q[rd_ptr_q][4];
    assign pix_eof     = mem_q[rd_ptr_q][5];

endmodule
